// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: one Galois step function and a set of primitive polynomials.
// The step function works on 32-bit containers so any width from 2 to 32 can share it.
package lfsr_pkg;

  localparam logic [3:0]  POLY4  = 4'h3;
  localparam logic [6:0]  POLY7  = 7'h41;
  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h002D;
  localparam logic [30:0] POLY31 = 31'h00000009;

  typedef struct packed {
    logic        out_bit;
    logic [31:0] next;
  } step_t;

  // Bits of the state above n are masked off, so the result stays zero-extended.
  function automatic step_t lfsr_step(input logic [31:0] state,
                                      input logic [31:0] poly,
                                      input int          n);
    logic [31:0] mask;
    logic        fb;
    step_t       res;
    mask        = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    fb          = |(state & (32'h1 << (n - 1)));
    res.out_bit = fb;
    res.next    = ((state << 1) & mask) ^ (poly & {32{fb}});
    return res;
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_if.sv
// Output stream of the PRBS generator: registered word plus valid/ready handshake.
interface lfsr_prbs_gen_if #(
  parameter int STEP = 1
);

  logic [STEP-1:0] o_data;
  logic            o_valid;
  logic            i_ready;
  logic            o_wrap;

  modport master (output o_data, output o_valid, output o_wrap, input  i_ready);
  modport slave  (input  o_data, input  o_valid, input  o_wrap, output i_ready);

endinterface

// File: rtl/lfsr_step_chain.sv
// Combinational chain of STEP Galois steps; collects the output bits MSB-first and
// flags when any intermediate state lands back on the start seed.
module lfsr_step_chain
  import lfsr_pkg::*;
#(
  parameter int            N    = 8,
  parameter logic [N-1:0]  POLY = N'(8'h9B),
  parameter int            STEP = 1
) (
  input  logic [N-1:0]    state,
  input  logic [N-1:0]    start_seed,
  output logic [N-1:0]    next_state,
  output logic [STEP-1:0] word,
  output logic            wrap_hit
);

  step_t        res;
  logic [N-1:0] cur;

  // Shifting left each step leaves the first-generated bit in the MSB.
  always_comb begin
    cur      = state;
    word     = '0;
    wrap_hit = 1'b0;
    res      = '0;
    for (int i = 0; i < STEP; i++) begin
      res      = lfsr_step(32'(cur), 32'(POLY), N);
      word     = (word << 1) | STEP'(res.out_bit);
      wrap_hit = wrap_hit | (res.next == 32'(start_seed));
      cur      = res.next[N-1:0];
    end
    next_state = cur;
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Galois LFSR PRBS generator: STEP bits per word on a valid/ready stream, with seed
// load, zero-seed replacement and sequence-wrap flag.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int           N            = 8,
  parameter logic [N-1:0] POLY         = N'(8'h9B),
  parameter int           STEP         = 1,
  parameter logic [N-1:0] DEFAULT_SEED = N'(1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [N-1:0]           i_seed,
  output logic                   o_seed_fixed,
  output logic [N-1:0]           o_state,
  lfsr_prbs_gen_if.master        stream
);

  logic [N-1:0]    state;
  logic [N-1:0]    start_seed;
  logic [N-1:0]    next_state;
  logic [N-1:0]    load_val;
  logic [STEP-1:0] word;
  logic [STEP-1:0] data_q;
  logic            wrap_hit;
  logic            wrap_q;
  logic            valid_q;
  logic            seed_fixed_q;
  logic            adv;

  lfsr_step_chain #(
    .N    (N),
    .POLY (POLY),
    .STEP (STEP)
  ) u_chain (
    .state      (state),
    .start_seed (start_seed),
    .next_state (next_state),
    .word       (word),
    .wrap_hit   (wrap_hit)
  );

  // A zero seed would lock the LFSR at zero forever, so it is swapped for the default.
  assign load_val = (i_seed == '0) ? DEFAULT_SEED : i_seed;
  assign adv      = i_en && !i_load && (!valid_q || stream.i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= DEFAULT_SEED;
      start_seed   <= DEFAULT_SEED;
      data_q       <= '0;
      wrap_q       <= 1'b0;
      valid_q      <= 1'b0;
      seed_fixed_q <= 1'b0;
    end else begin
      seed_fixed_q <= 1'b0;
      if (i_load) begin
        state        <= load_val;
        start_seed   <= load_val;
        valid_q      <= 1'b0;
        seed_fixed_q <= (i_seed == '0);
      end else if (adv) begin
        data_q  <= word;
        wrap_q  <= wrap_hit;
        state   <= next_state;
        valid_q <= 1'b1;
      end else if (valid_q && stream.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign stream.o_data  = data_q;
  assign stream.o_valid = valid_q;
  assign stream.o_wrap  = wrap_q;
  assign o_seed_fixed   = seed_fixed_q;
  assign o_state        = state;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: three instances (8-bit words, 8-bit serial,
// 4-bit serial) with hand-computed expected words queued ahead of the stream monitors.
module tb_lfsr_prbs_gen;

  typedef struct packed {
    logic [7:0] data;
    logic       wrap;
    logic [7:0] state;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       en_a, load_a, rdy_a, fix_a;
  logic [7:0] seed_a, state_a;
  logic       en_b, load_b, rdy_b, fix_b;
  logic [7:0] seed_b, state_b;
  logic       en_c, load_c, rdy_c, fix_c;
  logic [3:0] seed_c, state_c;

  int checks = 0;
  int fails  = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t got_a, got_b, got_c, exp_a, exp_b, exp_c;

  // x^4+x+1 from seed 1: output bits and states for one full period of 15 steps.
  logic       c_bits   [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] c_states [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                                4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

  lfsr_prbs_gen_if #(.STEP(8)) if_a ();
  lfsr_prbs_gen_if #(.STEP(1)) if_b ();
  lfsr_prbs_gen_if #(.STEP(1)) if_c ();

  assign if_a.i_ready = rdy_a;
  assign if_b.i_ready = rdy_b;
  assign if_c.i_ready = rdy_c;

  lfsr_prbs_gen #(.N(8), .POLY(8'h9B), .STEP(8), .DEFAULT_SEED(8'h01)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_load(load_a), .i_seed(seed_a),
    .o_seed_fixed(fix_a), .o_state(state_a), .stream(if_a)
  );

  lfsr_prbs_gen #(.N(8), .POLY(8'h9B), .STEP(1), .DEFAULT_SEED(8'h01)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_load(load_b), .i_seed(seed_b),
    .o_seed_fixed(fix_b), .o_state(state_b), .stream(if_b)
  );

  lfsr_prbs_gen #(.N(4), .POLY(4'h3), .STEP(1), .DEFAULT_SEED(4'h1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c), .i_load(load_c), .i_seed(seed_c),
    .o_seed_fixed(fix_c), .o_state(state_c), .stream(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Sets one instance's inputs, then advances the given number of cycles to just after posedge.
  task automatic applyStimulus(input int sel, input logic en, input logic load,
                               input logic ready, input logic [7:0] seed, input int cycles);
    case (sel)
      0: begin en_a = en; load_a = load; rdy_a = ready; seed_a = seed; end
      1: begin en_b = en; load_b = load; rdy_b = ready; seed_b = seed; end
      default: begin en_c = en; load_c = load; rdy_c = ready; seed_c = seed[3:0]; end
    endcase
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void push_exp(input int sel, input logic [7:0] d, input logic w,
                                   input logic [7:0] s);
    exp_t e;
    e = '{data: d, wrap: w, state: s};
    case (sel)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endfunction

  function automatic void push_a_first3();
    push_exp(0, 8'h01, 1'b0, 8'h9B);
    push_exp(0, 8'hE2, 1'b0, 8'h16);
    push_exp(0, 8'h1A, 1'b0, 8'h5E);
  endfunction

  // Monitors: a word is consumed on a clock edge where valid && ready and no load overrides it.
  always @(negedge clk) begin
    if (rst_n && if_a.o_valid && rdy_a && !load_a) begin
      got_a = '{data: if_a.o_data, wrap: if_a.o_wrap, state: state_a};
      if (q_a.size() == 0) checkOutput("mon_a_unexpected", 32'(got_a), 32'h0);
      else begin
        exp_a = q_a.pop_front();
        checkOutput("mon_a_word", 32'(got_a), 32'(exp_a));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_b.o_valid && rdy_b && !load_b) begin
      got_b = '{data: 8'(if_b.o_data), wrap: if_b.o_wrap, state: state_b};
      if (q_b.size() == 0) checkOutput("mon_b_unexpected", 32'(got_b), 32'h0);
      else begin
        exp_b = q_b.pop_front();
        checkOutput("mon_b_word", 32'(got_b), 32'(exp_b));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_c.o_valid && rdy_c && !load_c) begin
      got_c = '{data: 8'(if_c.o_data), wrap: if_c.o_wrap, state: 8'(state_c)};
      if (q_c.size() == 0) checkOutput("mon_c_unexpected", 32'(got_c), 32'h0);
      else begin
        exp_c = q_c.pop_front();
        checkOutput("mon_c_word", 32'(got_c), 32'(exp_c));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en_a = 0; load_a = 0; rdy_a = 1; seed_a = '0;
    en_b = 0; load_b = 0; rdy_b = 1; seed_b = '0;
    en_c = 0; load_c = 0; rdy_c = 1; seed_c = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid_a", 32'(if_a.o_valid), 32'h0);
    checkOutput("rst_data_a",  32'(if_a.o_data),  32'h0);
    checkOutput("rst_wrap_a",  32'(if_a.o_wrap),  32'h0);
    checkOutput("rst_fix_a",   32'(fix_a),        32'h0);
    checkOutput("rst_state_a", 32'(state_a),      32'h01);
    checkOutput("rst_state_c", 32'(state_c),      32'h1);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 8'h00, 1);

    $display("[TB] 8-bit words from reset seed");
    push_a_first3();
    applyStimulus(0, 1, 0, 1, 8'h00, 0);
    checkOutput("latency_pre", 32'(if_a.o_valid), 32'h0);
    applyStimulus(0, 1, 0, 1, 8'h00, 1);
    checkOutput("latency_post", 32'(if_a.o_valid), 32'h1);
    applyStimulus(0, 1, 0, 1, 8'h00, 2);
    applyStimulus(0, 0, 0, 1, 8'h00, 2);
    checkOutput("accept_no_refill", 32'(if_a.o_valid), 32'h0);
    checkOutput("frozen_state", 32'(state_a), 32'h5E);

    $display("[TB] backpressure");
    push_exp(0, 8'h6D, 1'b0, 8'h8F);
    push_exp(0, 8'hFB, 1'b0, 8'hE5);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(if_a.o_valid), 32'h1);
      checkOutput("bp_data",  32'(if_a.o_data),  32'h6D);
      checkOutput("bp_state", 32'(state_a),      32'h8F);
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
    end
    applyStimulus(0, 1, 0, 1, 8'h00, 1);
    applyStimulus(0, 0, 0, 1, 8'h00, 2);

    $display("[TB] zero-seed load over a pending word");
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    checkOutput("pending_before_load", 32'(if_a.o_valid), 32'h1);
    applyStimulus(0, 0, 1, 1, 8'h00, 1);
    checkOutput("load_discard", 32'(if_a.o_valid), 32'h0);
    checkOutput("load_state",   32'(state_a),      32'h01);
    checkOutput("fix_pulse",    32'(fix_a),        32'h1);
    applyStimulus(0, 0, 0, 1, 8'h00, 1);
    checkOutput("fix_pulse_end", 32'(fix_a), 32'h0);
    push_exp(0, 8'h01, 1'b0, 8'h9B);
    applyStimulus(0, 1, 0, 1, 8'h00, 2);
    applyStimulus(0, 1, 0, 0, 8'h00, 2);
    checkOutput("pending_data", 32'(if_a.o_data), 32'hE2);

    $display("[TB] 8-bit serial from seed 01 and 9B");
    applyStimulus(1, 0, 1, 1, 8'h01, 1);
    checkOutput("nz_seed_no_fix", 32'(fix_b), 32'h0);
    for (int i = 0; i < 7; i++) push_exp(1, 8'h00, 1'b0, 8'(8'h02 << i));
    push_exp(1, 8'h01, 1'b0, 8'h9B);
    applyStimulus(1, 1, 0, 1, 8'h00, 8);
    applyStimulus(1, 0, 0, 1, 8'h00, 1);
    checkOutput("b_state_8", 32'(state_b), 32'h9B);
    applyStimulus(1, 0, 1, 1, 8'h9B, 1);
    push_exp(1, 8'h01, 1'b0, 8'hAD);
    push_exp(1, 8'h01, 1'b0, 8'hC1);
    push_exp(1, 8'h01, 1'b0, 8'h19);
    push_exp(1, 8'h00, 1'b0, 8'h32);
    applyStimulus(1, 1, 0, 1, 8'h00, 4);
    applyStimulus(1, 0, 0, 1, 8'h00, 1);

    $display("[TB] 4-bit wrap over 45 words");
    applyStimulus(2, 0, 1, 1, 8'h01, 1);
    for (int i = 0; i < 45; i++)
      push_exp(2, 8'(c_bits[i % 15]), (i % 15) == 14, 8'(c_states[i % 15]));
    applyStimulus(2, 1, 0, 1, 8'h00, 45);
    applyStimulus(2, 0, 0, 1, 8'h00, 1);

    $display("[TB] asynchronous reset with a pending word");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(if_a.o_valid), 32'h0);
    checkOutput("async_rst_state", 32'(state_a),      32'h01);
    checkOutput("async_rst_data",  32'(if_a.o_data),  32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 8'h00, 1);
    push_a_first3();
    applyStimulus(0, 1, 0, 1, 8'h00, 3);
    applyStimulus(0, 0, 0, 1, 8'h00, 2);
    checkOutput("restart_state", 32'(state_a), 32'h5E);

    checkOutput("q_a_drained", 32'(q_a.size()), 32'h0);
    checkOutput("q_b_drained", 32'(q_b.size()), 32'h0);
    checkOutput("q_c_drained", 32'(q_c.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
